// File: rtl/pusch_scrambler_par_if.sv
// pusch_scrambler_par_if
// Bundles the configuration, input stream, output stream and status signals of
// pusch_scrambler_par.
//   master : drives config/start, the input beat (in_data/in_valid) and out_ready
//   slave  : the scrambler; drives in_ready, out_data/out_valid/out_last and busy
// When PSC_PLACEHOLDER_EN is defined, an extra 2-bit-per-data-bit tag field
// (in_tag) travels with each input beat.
interface pusch_scrambler_par_if #(
  parameter int unsigned W     = 8,
  parameter int unsigned LEN_W = 20
);
  logic             start;
  logic             cfg_hl;
  logic [9:0]       n_id;
  logic [9:0]       n_cell_id;
  logic [15:0]      n_rnti;
  logic [LEN_W-1:0] e_len;
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic             busy;
`ifdef PSC_PLACEHOLDER_EN
  logic [2*W-1:0]   in_tag;
`endif

  modport master (
`ifdef PSC_PLACEHOLDER_EN
    output in_tag,
`endif
    output start, cfg_hl, n_id, n_cell_id, n_rnti, e_len, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy
  );

  modport slave (
`ifdef PSC_PLACEHOLDER_EN
    input  in_tag,
`endif
    input  start, cfg_hl, n_id, n_cell_id, n_rnti, e_len, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/pusch_scrambler_par.sv
// pusch_scrambler_par
// W-bit-parallel PUSCH scrambler: XORs each codeword bit with the Gold sequence
// c(n) = x1(n+NC) ^ x2(n+NC). START latches the configuration, the two LFSRs are
// warmed up NC bits (NC/W cycles), then input beats are scrambled with a
// one-entry output register and valid/ready handshaking on both sides.
// Ports:
//   clk_psc : clock
//   rst_psc : synchronous active-high reset
//   bus     : pusch_scrambler_par_if.slave (config, start, in/out streams, busy)
// Optional feature (macro PSC_PLACEHOLDER_EN): per-bit tags on in_tag select
// plain data (00/11), marker 'x' (01, output 1) or 'y' (10, repeat the
// previous output bit, chained across beats). Without the macro every bit is
// scrambled as data and in_tag does not exist.
module pusch_scrambler_par #(
  parameter int unsigned W     = 8,
  parameter int unsigned NC    = 1600,
  parameter int unsigned LEN_W = 20
) (
  input logic                   clk_psc,
  input logic                   rst_psc,
  pusch_scrambler_par_if.slave  bus
);

  localparam int unsigned WarmCycles = NC / W;
  localparam int unsigned WarmW      = $clog2(WarmCycles + 1);
  // One extra bit so counter + W never wraps for the largest E.
  localparam int unsigned CntW       = LEN_W + 1;

  typedef enum logic [1:0] {StIdle, StWarm, StRun} state_e;

  state_e           state_q;
  logic [WarmW-1:0] warm_q;
  logic [30:0]      x1_q, x2_q;
  logic [CntW-1:0]  cnt_q, len_q;
  logic             fin_q;       // last input beat already taken
  logic [W-1:0]     out_data_q;
  logic             out_valid_q, out_last_q, busy_q;
`ifdef PSC_PLACEHOLDER_EN
  logic             prev_q;      // last output bit of the previous beat, for 'y'
`endif

  logic [30:0]      c_init;
  logic [30:0]      x1_adv, x2_adv;
  logic [W-1:0]     c_bits;
  logic [W-1:0]     beat_raw, beat;
  logic [CntW-1:0]  remain;
  logic             in_ready, xfer, is_last;

  assign c_init = {bus.n_rnti, 15'b0} + 31'(bus.cfg_hl ? bus.n_id : bus.n_cell_id);

  // W unrolled LFSR steps; bit 0 of each state is the sequence value at the
  // current position, so c_bits[k] is c for the k-th bit of this beat.
  always_comb begin
    x1_adv = x1_q;
    x2_adv = x2_q;
    c_bits = '0;
    for (int k = 0; k < int'(W); k++) begin
      c_bits[k] = x1_adv[0] ^ x2_adv[0];
      x1_adv    = {x1_adv[3] ^ x1_adv[0], x1_adv[30:1]};
      x2_adv    = {x2_adv[3] ^ x2_adv[2] ^ x2_adv[1] ^ x2_adv[0], x2_adv[30:1]};
    end
  end

  assign in_ready = (state_q == StRun) && !fin_q && (!out_valid_q || bus.out_ready);
  assign xfer     = bus.in_valid && in_ready;
  assign is_last  = (cnt_q + CntW'(W)) >= len_q;
  assign remain   = len_q - cnt_q;

  always_comb begin
`ifdef PSC_PLACEHOLDER_EN
    logic prev_bit;
    prev_bit = prev_q;
    beat_raw = '0;
    for (int i = 0; i < int'(W); i++) begin
      case (bus.in_tag[2*i +: 2])
        2'b01:   beat_raw[i] = 1'b1;
        2'b10:   beat_raw[i] = prev_bit;
        default: beat_raw[i] = bus.in_data[i] ^ c_bits[i];
      endcase
      prev_bit = beat_raw[i];
    end
`else
    beat_raw = bus.in_data ^ c_bits;
`endif
    // Bits past the end of the codeword are zeroed on the final beat.
    beat = '0;
    for (int i = 0; i < int'(W); i++) begin
      beat[i] = (CntW'(i) < remain) ? beat_raw[i] : 1'b0;
    end
  end

  always_ff @(posedge clk_psc) begin
    if (rst_psc) begin
      state_q     <= StIdle;
      warm_q      <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      fin_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PSC_PLACEHOLDER_EN
      prev_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            x1_q    <= 31'd1;
            x2_q    <= c_init;
            len_q   <= {1'b0, bus.e_len};
            cnt_q   <= '0;
            warm_q  <= '0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StWarm;
`ifdef PSC_PLACEHOLDER_EN
            prev_q  <= 1'b0;
`endif
          end
        end
        StWarm: begin
          x1_q   <= x1_adv;
          x2_q   <= x2_adv;
          warm_q <= warm_q + 1'b1;
          if (warm_q == WarmW'(WarmCycles - 1)) state_q <= StRun;
        end
        StRun: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (out_last_q) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
          // A new beat may load in the same cycle the old one drains.
          if (xfer) begin
            out_data_q  <= beat;
            out_valid_q <= 1'b1;
            out_last_q  <= is_last;
            fin_q       <= is_last;
            x1_q        <= x1_adv;
            x2_q        <= x2_adv;
            cnt_q       <= cnt_q + CntW'(W);
`ifdef PSC_PLACEHOLDER_EN
            prev_q      <= beat_raw[W-1];
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pusch_scrambler_par.sv
// Bench for pusch_scrambler_par (W=8): table of codeword vectors checked against
// a bit-serial Gold sequence model, plus directed reset / start sequences.
module tb_pusch_scrambler_par;
  localparam int W  = 8;
  localparam int NC = 1600;
  localparam int MS = NC + 160;

  typedef struct {
    bit         cfg_hl;
    logic [9:0] n_id;
    logic [9:0] n_cell;
    logic [15:0] rnti;
    int         e_len;
    logic [7:0] data;
    bit         gaps;
    bit         stall;
    bit         poke;      // extra START during warm-up, must be ignored
    int         exp_beats;
    int         exp_warm;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pusch_scrambler_par_if #(.W(W), .LEN_W(20)) bus ();

  pusch_scrambler_par #(.W(W), .NC(NC), .LEN_W(20)) dut (
    .clk_psc (clk),
    .rst_psc (rst),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit         x1m [MS];
  bit         x2m [MS];
  bit         cexp [128];
  logic [7:0] exp_beat [16];
  logic [15:0] tag_beat [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Bit-serial reference: full x1/x2 sequences, then c(n) and per-beat outputs.
  task automatic build_expected(input vec_t v);
    logic [30:0] cinit;
    logic [1:0]  tg;
    bit          prev, o;
    int          n;
    cinit = {v.rnti, 15'b0} + 31'(v.cfg_hl ? v.n_id : v.n_cell);
    for (int i = 0; i < 31; i++) begin
      x1m[i] = (i == 0);
      x2m[i] = cinit[i];
    end
    for (int k = 0; k + 31 < MS; k++) begin
      x1m[k+31] = x1m[k+3] ^ x1m[k];
      x2m[k+31] = x2m[k+3] ^ x2m[k+2] ^ x2m[k+1] ^ x2m[k];
    end
    for (int k = 0; k < 128; k++) cexp[k] = x1m[k+NC] ^ x2m[k+NC];
    prev = 1'b0;
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < W; i++) begin
        n = b * W + i;
`ifdef PSC_PLACEHOLDER_EN
        tg = tag_beat[b][2*i +: 2];
`else
        tg = 2'b00;
`endif
        if (tg == 2'b01)      o = 1'b1;
        else if (tg == 2'b10) o = prev;
        else                  o = v.data[i] ^ cexp[n];
        prev = o;
        exp_beat[b][i] = (n < v.e_len) ? o : 1'b0;
      end
    end
  endtask

  task automatic start_and_warm(input vec_t v);
    int cnt;
    @(negedge clk);
    bus.cfg_hl    = v.cfg_hl;
    bus.n_id      = v.n_id;
    bus.n_cell_id = v.n_cell;
    bus.n_rnti    = v.rnti;
    bus.e_len     = 20'(v.e_len);
    bus.start     = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", 64'(bus.busy), 64'(1));
    check("ready_in_warm", 64'(bus.in_ready), 64'(0));
    cnt = 0;
    while (!bus.in_ready && cnt < 1000) begin
      bus.start = v.poke && (cnt == 50);
      if (v.poke && cnt == 50) begin
        bus.n_id   = ~v.n_id;
        bus.cfg_hl = ~v.cfg_hl;
      end
      @(negedge clk); #1;
      cnt++;
    end
    bus.start = 1'b0;
    check("warm_cycles", 64'(cnt), 64'(v.exp_warm));
  endtask

  task automatic run_vector(input vec_t v);
    build_expected(v);
    start_and_warm(v);
    fork
      begin : drv
        int gap, t;
        for (int b = 0; b < v.exp_beats; b++) begin
          gap = v.gaps ? int'($urandom_range(0, 2)) : 0;
          repeat (gap) begin
            bus.in_valid = 1'b0;
            @(negedge clk); #1;
          end
          bus.in_valid = 1'b1;
          bus.in_data  = v.data;
`ifdef PSC_PLACEHOLDER_EN
          bus.in_tag   = tag_beat[b];
`endif
          t = 0;
          while (!bus.in_ready && t < 2000) begin
            @(negedge clk); #1;
            t++;
          end
          check("drv_ready_wait", 64'(t < 2000), 64'(1));
          if (t >= 2000) break;
          @(negedge clk); #1;
        end
        bus.in_valid = 1'b0;
      end
      begin : mon
        int b, t;
        logic held;
        logic [7:0] hd;
        logic hlast;
        b = 0; t = 0; held = 1'b0; hd = '0; hlast = 1'b0;
        while (b < v.exp_beats && t < 3000) begin
          @(negedge clk);
          bus.out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
          #1;
          t++;
          if (bus.out_valid) begin
            if (held) begin
              check("stall_data", 64'(bus.out_data), 64'(hd));
              check("stall_last", 64'(bus.out_last), 64'(hlast));
            end
            if (bus.out_ready) begin
              check($sformatf("beat%0d_data", b), 64'(bus.out_data), 64'(exp_beat[b]));
              check($sformatf("beat%0d_last", b), 64'(bus.out_last),
                    64'(b == v.exp_beats - 1));
              held = 1'b0;
              b++;
              if (bus.out_last) break;
            end else begin
              held  = 1'b1;
              hd    = bus.out_data;
              hlast = bus.out_last;
            end
          end else if (held) begin
            check("valid_held", 64'(bus.out_valid), 64'(1));
            held = 1'b0;
          end
        end
        check("beat_count", 64'(b), 64'(v.exp_beats));
        bus.out_ready = 1'b1;
      end
    join
    @(negedge clk); #1;
    check("busy_done", 64'(bus.busy), 64'(0));
    check("ready_done", 64'(bus.in_ready), 64'(0));
    check("valid_done", 64'(bus.out_valid), 64'(0));
  endtask

  vec_t tbl [6];

  initial begin
    int t, beats;
    vec_t pv;

    tbl[0] = '{1'b1, 10'd17,  10'd0,    16'h1234, 64, 8'h00, 1'b0, 1'b0, 1'b0, 8, 200};
    tbl[1] = '{1'b0, 10'd17,  10'd500,  16'h1234, 64, 8'h00, 1'b0, 1'b0, 1'b0, 8, 200};
    tbl[2] = '{1'b1, 10'd17,  10'd0,    16'h1234, 20, 8'hFF, 1'b0, 1'b0, 1'b0, 3, 200};
    tbl[3] = '{1'b1, 10'd17,  10'd0,    16'h1234, 64, 8'h5A, 1'b1, 1'b1, 1'b0, 8, 200};
    tbl[4] = '{1'b0, 10'd0,   10'd1023, 16'hFFFF, 1,  8'hFF, 1'b0, 1'b1, 1'b1, 1, 200};
    tbl[5] = '{1'b1, 10'd999, 10'd3,    16'hBEEF, 63, 8'hA5, 1'b1, 1'b1, 1'b0, 8, 200};
    for (int i = 0; i < 16; i++) tag_beat[i] = '0;

    bus.start = 1'b0; bus.cfg_hl = 1'b0; bus.n_id = '0; bus.n_cell_id = '0;
    bus.n_rnti = '0; bus.e_len = '0; bus.in_data = '0; bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
`ifdef PSC_PLACEHOLDER_EN
    bus.in_tag = '0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_last", 64'(bus.out_last), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    rst = 1'b0;

    // No acceptance while idle
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check("idle_in_ready", 64'(bus.in_ready), 64'(0));
      check("idle_out_valid", 64'(bus.out_valid), 64'(0));
    end
    bus.in_valid = 1'b0;

    for (int i = 0; i < 6; i++) run_vector(tbl[i]);

    // Reset while the third beat is on the output, then a fresh codeword
    build_expected(tbl[0]);
    start_and_warm(tbl[0]);
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    beats = 0; t = 0;
    while (beats < 3 && t < 500) begin
      @(negedge clk); #1;
      t++;
      if (bus.out_valid) beats++;
    end
    check("rst_mid_beats", 64'(beats), 64'(3));
    check("rst_mid_beat3", 64'(bus.out_data), 64'(exp_beat[2]));
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk); #1;
    check("rst_mid_valid", 64'(bus.out_valid), 64'(0));
    check("rst_mid_last", 64'(bus.out_last), 64'(0));
    check("rst_mid_data", 64'(bus.out_data), 64'(0));
    check("rst_mid_busy", 64'(bus.busy), 64'(0));
    check("rst_mid_ready", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    run_vector(tbl[0]);

    // START coinciding with reset is dropped
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy0", 64'(bus.busy), 64'(0));
    @(negedge clk); #1;
    check("rst_start_busy1", 64'(bus.busy), 64'(0));

`ifdef PSC_PLACEHOLDER_EN
    // x at bit2, y at bit3 of beat 0; y at bit0 and tag 11 at bit5 of beat 1
    pv = '{1'b1, 10'd17, 10'd0, 16'h1234, 16, 8'h00, 1'b0, 1'b0, 1'b0, 2, 200};
    tag_beat[0] = 16'h0090;
    tag_beat[1] = 16'h0C02;
    run_vector(pv);
    check("ph_bit2", 64'(exp_beat[0][2]), 64'(1));
    tag_beat[0] = '0;
    tag_beat[1] = '0;
    bus.in_tag  = '0;
`else
    pv = tbl[0];
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
